// File: rtl/ss_xfer_fifo.sv
// Data buffer and flow controller between the read and write ss_sg engines of one ADMA copy job.
// The read engine pushes 64-bit beats, the write engine pops them; job sequencing and start/stop/end flow are driven here.
module ss_xfer_fifo #(
    parameter int unsigned AW         = 4,
    parameter int unsigned SRC_RESUME = 8,
    parameter int unsigned DST_BURST  = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n,
    input  logic          job_go,
    input  logic          job_abort,
    input  logic [63:0]   src_dat,
    input  logic          src_xfer,
    input  logic          src_last,
    input  logic          src_c_done,
    output logic          src_start,
    output logic          src_stop,
    output logic          src_end,
    input  logic          dst_xfer,
    input  logic          dst_c_done,
    output logic [63:0]   dst_dat,
    output logic          dst_start,
    output logic          dst_stop,
    output logic          dst_end,
    output logic          ss_done,
    output logic          job_done,
    output logic          job_err,
    output logic [AW:0]   level,
    output logic [1:0]    xf_state
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LVL_W = AW + 1;

    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_HIWAT  = LVL_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_RESUME = LVL_W'(SRC_RESUME);
    localparam logic [LVL_W-1:0] LVL_BURST  = LVL_W'(DST_BURST);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            eos;
    logic            ovf;
    logic            udf;
    logic [63:0]     mem [DEPTH];

    logic            push_req;
    logic            push_ok;
    logic            pop_ok;
    logic            lvl_empty;
    logic            in_run;
    logic            in_drain;
    logic            in_flush;

    assign lvl_empty = (level == '0);
    assign in_run    = (state == S_RUN);
    assign in_drain  = (state == S_DRAIN);
    assign in_flush  = (state == S_FLUSH);

    assign push_req = src_xfer & ~src_last & (in_run | in_drain);
    assign push_ok  = push_req & (level != LVL_FULL);
    assign pop_ok   = dst_xfer & ~lvl_empty;

    // Storage array; contents are only observable while level != 0
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= src_dat;
        end
    end

    // Job FSM, pointers, level and sticky status
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            eos      <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            ss_done  <= 1'b0;
            job_done <= 1'b0;
            job_err  <= 1'b0;
        end else begin
            ss_done  <= 1'b0;
            job_done <= 1'b0;

            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_req && !push_ok)  ovf <= 1'b1;
            if (dst_xfer && lvl_empty) udf <= 1'b1;

            if (push_ok && !pop_ok) begin
                level <= level + LVL_ONE;
            end else if (!push_ok && pop_ok) begin
                level <= level - LVL_ONE;
            end

            case (state)
                S_IDLE: begin
                    if (job_go) begin
                        state   <= S_RUN;
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        level   <= '0;
                        eos     <= 1'b0;
                        ovf     <= 1'b0;
                        udf     <= 1'b0;
                        job_err <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (job_abort) begin
                        state <= S_FLUSH;
                    end else if (src_xfer && src_last) begin
                        eos   <= 1'b1;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (job_abort) begin
                        state <= S_FLUSH;
                    end else if (lvl_empty && src_c_done && dst_c_done) begin
                        state    <= S_IDLE;
                        ss_done  <= 1'b1;
                        job_done <= 1'b1;
                        job_err  <= ovf | udf;
                    end
                end
                S_FLUSH: begin
                    if (src_c_done && dst_c_done) begin
                        state    <= S_IDLE;
                        ss_done  <= 1'b1;
                        job_done <= 1'b1;
                        job_err  <= 1'b1;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        level    <= '0;
                    end
                end
            endcase
        end
    end

    assign xf_state = state;
    assign dst_dat  = lvl_empty ? 64'd0 : mem[rd_ptr];

    // Flow controls depend only on registered state and level
    assign src_start = in_run & ~eos & ((LVL_FULL - level) >= LVL_RESUME);
    assign src_stop  = (level >= LVL_HIWAT);
    assign src_end   = in_flush;
    assign dst_start = (in_run | in_drain) & ((level >= LVL_BURST) | (eos & ~lvl_empty));
    // Qualified by an active job so every output reads 0 while idle
    assign dst_stop  = (state != S_IDLE) & (level <= LVL_ONE);
    assign dst_end   = in_flush | (in_drain & lvl_empty);

endmodule

// File: tb/tb_ss_xfer_fifo.sv
// Scoreboard bench for ss_xfer_fifo: copy, backpressure, wrap, dst gating, abort and error paths.
module tb_ss_xfer_fifo;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        job_go = 1'b0, job_abort = 1'b0;
    logic [63:0] src_dat = '0;
    logic        src_xfer = 1'b0, src_last = 1'b0, src_c_done = 1'b0;
    logic        dst_xfer = 1'b0, dst_c_done = 1'b0;
    logic        src_start, src_stop, src_end;
    logic [63:0] dst_dat;
    logic        dst_start, dst_stop, dst_end;
    logic        ss_done, job_done, job_err;
    logic [4:0]  level;
    logic [1:0]  xf_state;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb [$];
    int mlvl;

    ss_xfer_fifo #(.AW(4), .SRC_RESUME(8), .DST_BURST(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n),
        .job_go(job_go), .job_abort(job_abort),
        .src_dat(src_dat), .src_xfer(src_xfer), .src_last(src_last), .src_c_done(src_c_done),
        .src_start(src_start), .src_stop(src_stop), .src_end(src_end),
        .dst_xfer(dst_xfer), .dst_c_done(dst_c_done), .dst_dat(dst_dat),
        .dst_start(dst_start), .dst_stop(dst_stop), .dst_end(dst_end),
        .ss_done(ss_done), .job_done(job_done), .job_err(job_err),
        .level(level), .xf_state(xf_state)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic start_job();
        job_go = 1'b1;
        tick();
        job_go = 1'b0;
        mlvl = 0;
    endtask

    // One source beat; expected data is queued only when it should land
    task automatic push_word(input logic [63:0] d);
        src_dat  = d;
        src_xfer = 1'b1;
        if (mlvl < 16) begin
            sb.push_back(d);
            mlvl++;
        end
        tick();
        src_xfer = 1'b0;
    endtask

    task automatic send_last();
        src_xfer = 1'b1;
        src_last = 1'b1;
        tick();
        src_xfer = 1'b0;
        src_last = 1'b0;
    endtask

    task automatic both_done();
        src_c_done = 1'b1;
        dst_c_done = 1'b1;
        tick();
        src_c_done = 1'b0;
        dst_c_done = 1'b0;
    endtask

    // Pop n words, checking each head word against the scoreboard before its beat
    task automatic pop_check(input int n, input string tag);
        logic [63:0] e;
        for (int i = 0; i < n; i++) begin
            e = sb.pop_front();
            total++; if (dst_dat !== e) begin bad++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, dst_dat, e); end
            dst_xfer = 1'b1;
            tick();
            mlvl--;
        end
        dst_xfer = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_n = 1'b0;
        repeat (3) tick();
        total++; if (xf_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", xf_state); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if ({src_start, src_stop, src_end, dst_start, dst_stop, dst_end, ss_done, job_done, job_err} !== 9'd0)
            begin bad++; $display("FAIL reset_outs: got %b want 0", {src_start, src_stop, src_end, dst_start, dst_stop, dst_end, ss_done, job_done, job_err}); end
        total++; if (dst_dat !== 64'd0) begin bad++; $display("FAIL reset_dat: got %h want 0", dst_dat); end
        wb_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_copy();
        start_job();
        total++; if (xf_state !== 2'd1) begin bad++; $display("FAIL copy_run: got %0d want 1", xf_state); end
        for (int i = 0; i < 10; i++) push_word({$urandom, $urandom});
        total++; if (level !== 5'd10) begin bad++; $display("FAIL copy_level: got %0d want 10", level); end
        total++; if (dst_start !== 1'b1) begin bad++; $display("FAIL copy_dst_start: got %b want 1", dst_start); end
        send_last();
        total++; if (xf_state !== 2'd2) begin bad++; $display("FAIL copy_drain: got %0d want 2", xf_state); end
        total++; if (src_start !== 1'b0) begin bad++; $display("FAIL copy_src_start_eos: got %b want 0", src_start); end
        pop_check(10, "copy");
        total++; if (level !== 5'd0 || dst_end !== 1'b1) begin bad++; $display("FAIL copy_dst_end: got level=%0d end=%b want 0/1", level, dst_end); end
        total++; if (dst_dat !== 64'd0) begin bad++; $display("FAIL copy_empty_dat: got %h want 0", dst_dat); end
        both_done();
        total++; if ({ss_done, job_done, job_err, xf_state} !== 5'b11000) begin bad++; $display("FAIL copy_done: got %b want 11000", {ss_done, job_done, job_err, xf_state}); end
        tick();
        total++; if ({ss_done, job_done} !== 2'b00) begin bad++; $display("FAIL copy_pulse: got %b want 00", {ss_done, job_done}); end
    endtask

    task automatic test_backpressure();
        logic stop_seen;
        start_job();
        for (int i = 0; i < 20; i++) begin
            total++; if (src_stop !== (mlvl >= 15)) begin bad++; $display("FAIL bp_stop[%0d]: got %b want %b", i, src_stop, mlvl >= 15); end
            total++; if (src_start !== (mlvl <= 8)) begin bad++; $display("FAIL bp_start[%0d]: got %b want %b", i, src_start, mlvl <= 8); end
            stop_seen = src_stop;
            push_word(64'hB000 + 64'(i));
            if (stop_seen) break;
        end
        total++; if (level !== 5'd16 || mlvl != 16) begin bad++; $display("FAIL bp_full: got %0d want 16", level); end
        while (mlvl > 0) begin
            total++; if (src_start !== (mlvl <= 8)) begin bad++; $display("FAIL bp_resume[%0d]: got %b want %b", mlvl, src_start, mlvl <= 8); end
            pop_check(1, "bp");
        end
        send_last();
        both_done();
        total++; if ({job_done, job_err} !== 2'b10) begin bad++; $display("FAIL bp_no_ovf: got %b want 10", {job_done, job_err}); end
        tick();
    endtask

    task automatic test_wrap();
        logic [63:0] e;
        start_job();
        for (int i = 0; i < 4; i++) push_word(64'hA000 + 64'(i));
        for (int i = 4; i < 40; i++) begin
            e = sb.pop_front();
            total++; if (dst_dat !== e) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, dst_dat, e); end
            sb.push_back(64'hA000 + 64'(i));
            src_dat  = 64'hA000 + 64'(i);
            src_xfer = 1'b1;
            dst_xfer = 1'b1;
            tick();
            total++; if (level !== 5'd4) begin bad++; $display("FAIL wrap_level[%0d]: got %0d want 4", i, level); end
        end
        src_xfer = 1'b0;
        dst_xfer = 1'b0;
        pop_check(4, "wrap_tail");
        send_last();
        both_done();
        total++; if ({job_done, job_err} !== 2'b10) begin bad++; $display("FAIL wrap_done: got %b want 10", {job_done, job_err}); end
        tick();
    endtask

    task automatic test_gating();
        start_job();
        for (int i = 0; i < 3; i++) push_word(64'hC000 + 64'(i));
        total++; if ({dst_start, dst_stop} !== 2'b00) begin bad++; $display("FAIL gate_pre_eos: got %b want 00", {dst_start, dst_stop}); end
        send_last();
        total++; if (dst_start !== 1'b1) begin bad++; $display("FAIL gate_post_eos: got %b want 1", dst_start); end
        pop_check(2, "gate");
        total++; if ({level, dst_start, dst_stop} !== {5'd1, 2'b11}) begin bad++; $display("FAIL gate_lvl1: got %0d/%b%b want 1/11", level, dst_start, dst_stop); end
        pop_check(1, "gate_last");
        total++; if ({dst_start, dst_end} !== 2'b01) begin bad++; $display("FAIL gate_empty: got %b want 01", {dst_start, dst_end}); end
        both_done();
        total++; if ({job_done, job_err} !== 2'b10) begin bad++; $display("FAIL gate_done: got %b want 10", {job_done, job_err}); end
        tick();
    endtask

    task automatic test_abort();
        start_job();
        for (int i = 0; i < 5; i++) push_word(64'hD000 + 64'(i));
        total++; if (level !== 5'd5) begin bad++; $display("FAIL abort_level: got %0d want 5", level); end
        job_abort = 1'b1;
        tick();
        job_abort = 1'b0;
        total++; if ({xf_state, src_end, dst_end} !== 4'b1111) begin bad++; $display("FAIL abort_flush: got %b want 1111", {xf_state, src_end, dst_end}); end
        src_dat = 64'hDEAD; src_xfer = 1'b1; job_go = 1'b1;
        tick();
        src_xfer = 1'b0; job_go = 1'b0;
        total++; if (level !== 5'd5 || xf_state !== 2'd3) begin bad++; $display("FAIL abort_ignore: got %0d/%0d want 5/3", level, xf_state); end
        both_done();
        total++; if ({ss_done, job_done, job_err, level, xf_state} !== {3'b111, 5'd0, 2'd0}) begin bad++; $display("FAIL abort_done: got %b want 1110000000", {ss_done, job_done, job_err, level, xf_state}); end
        sb.delete();
        tick();
        start_job();
        job_abort = 1'b1; src_xfer = 1'b1; src_last = 1'b1;
        tick();
        job_abort = 1'b0; src_xfer = 1'b0; src_last = 1'b0;
        total++; if (xf_state !== 2'd3) begin bad++; $display("FAIL abort_wins: got %0d want 3", xf_state); end
        both_done();
        total++; if ({job_done, job_err} !== 2'b11) begin bad++; $display("FAIL abort_wins_done: got %b want 11", {job_done, job_err}); end
        tick();
    endtask

    task automatic test_errors();
        start_job();
        for (int i = 0; i < 17; i++) push_word(64'hE000 + 64'(i));
        total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level: got %0d want 16", level); end
        pop_check(16, "ovf");
        send_last();
        both_done();
        total++; if ({job_done, job_err} !== 2'b11) begin bad++; $display("FAIL ovf_err: got %b want 11", {job_done, job_err}); end
        tick();
        start_job();
        total++; if (job_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", job_err); end
        dst_xfer = 1'b1;
        tick();
        dst_xfer = 1'b0;
        total++; if (level !== 5'd0) begin bad++; $display("FAIL udf_level: got %0d want 0", level); end
        send_last();
        both_done();
        total++; if ({job_done, job_err} !== 2'b11) begin bad++; $display("FAIL udf_err: got %b want 11", {job_done, job_err}); end
        tick();
        start_job();
        for (int i = 0; i < 3; i++) push_word(64'hF000 + 64'(i));
        wb_rst_n = 1'b0;
        #1;
        total++; if ({xf_state, level} !== 7'd0) begin bad++; $display("FAIL rst_mid_state: got %0d/%0d want 0/0", xf_state, level); end
        total++; if ({src_start, src_stop, src_end, dst_start, dst_stop, dst_end, ss_done, job_done, job_err, dst_dat} !== 73'd0)
            begin bad++; $display("FAIL rst_mid_outs: got %b dat=%h want 0", {src_start, src_stop, src_end, dst_start, dst_stop, dst_end, ss_done, job_done, job_err}, dst_dat); end
        sb.delete();
        tick();
        wb_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        mlvl = 0;
        test_reset();
        test_copy();
        test_backpressure();
        test_wrap();
        test_gating();
        test_abort();
        test_errors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
